spectrum_bin_writer: RTL
========================

# spectrum_bin_writer

Write side of the spectrum bin RAM that the histogram display reads. Takes the per-frame stream of FFT magnitudes (one sample per bin, bin 0 first) and updates one 16-bit word per bin through a read-modify-write port of the dual-port bin RAM. Supports plain overwrite or peak-hold with exponential decay. Clears the RAM after reset. The display reads the other RAM port independently; frame tearing there is acceptable.

## Interface
- NBINS, 1024, bins per frame and RAM depth
- ADDR_W, 10, RAM address width (log2 NBINS)
- DATA_W, 16, magnitude and RAM word width
- DECAY_SHIFT, 3, peak-hold decay: old − (old >> DECAY_SHIFT) per frame
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  magnitude sample valid
- s_ready  out  1  writer can accept a sample
- s_data  in  DATA_W  unsigned magnitude for the current bin
- s_last  in  1  marks the final sample of a frame
- mode_peak  in  1  1 = peak-hold with decay, 0 = overwrite; sampled per accepted sample
- raddr  out  ADDR_W  RAM read address; rdata returns exactly 1 cycle later
- rdata  in  DATA_W  RAM read data
- waddr  out  ADDR_W  RAM write address
- wdata  out  DATA_W  RAM write data
- we  out  1  RAM write enable
- frame_done  out  1  one-cycle pulse with the write of a frame's last bin
- frame_err  out  1  sticky: frame length ≠ NBINS seen; cleared only by reset

## Operation
- States: CLEAR, RUN.
- Reset: all outputs 0, bin counter 0, pipeline valids 0, frame_err 0, state CLEAR. In-flight samples are dropped.
- CLEAR: s_ready = 0; each cycle we = 1, wdata = 0, waddr = clear counter, which runs 0 … NBINS−1 and takes NBINS cycles. After the NBINS−1 write, go to RUN. CLEAR is re-entered only by reset.
- RUN: s_ready = 1 continuously, with no backpressure. A sample is accepted on a cycle where s_valid && s_ready.
- Accepted sample: raddr = bin counter. The sample, mode and bin are carried one stage.
- Next stage: new = captured s_data and old = rdata.
  - Decayed value: dec = old − (old >> DECAY_SHIFT), unsigned; no underflow is possible.
  - Result: wdata = mode_peak ? max(new, dec) : new.
- Bin counter:
  - Increments by 1 per accepted sample.
  - On s_last it resets to 0 for the next frame.
  - On reaching NBINS−1 without s_last it also wraps to 0, treating that sample as last.
- frame_err is set when either:
  - s_last arrives at a bin < NBINS−1 (short frame), or
  - the counter wraps without s_last (long frame).
- frame_done pulses on every frame end, including erroneous ones.
- Bins increase monotonically within a frame, so no read-after-write hazard exists. The wrap to bin 0 reads a different address than the in-flight NBINS−1 write. No forwarding is required.
- Gaps (s_valid low) simply stall the counter; the pipeline drains normally.

## Timing
- Sample accepted in cycle N: raddr valid in cycle N, rdata in N+1, we/waddr/wdata registered and asserted in N+2.
- Throughput: 1 sample/cycle sustained.
- frame_done is asserted in the same cycle as the last bin's we.
- frame_err rises in the same cycle as the offending frame's frame_done.
- raddr is don't-care when no sample is accepted; it is held at the bin counter.
- After reset deasserts: NBINS clear cycles; s_ready rises in the cycle after the last clear write.

## Structure
- Shared package holds:
  - NBINS, ADDR_W, DATA_W defaults,
  - the state enum {CLEAR, RUN},
  - so the display reader and the writer agree on RAM geometry.
- One natural sub-module: bin_update, combinational (old, new, mode_peak) → wdata with the DECAY_SHIFT parameter. It is reusable for other decay displays.
- The top level holds the FSM, counters and the 2-stage pipeline.

## Test plan
- Reset release:
  - NBINS consecutive writes of 0 to addresses 0…1023, s_ready = 0 throughout;
  - s_ready = 1 on cycle 1025;
  - frame_err = 0.
- Overwrite mode (mode_peak = 0), 1024 back-to-back samples s_data = bin index, s_last on the final one:
  - we at N+2 with waddr = wdata = index;
  - frame_done coincides with waddr 1023.
- Peak mode, RAM model holding 800 at bin 5, frame sample 100 at bin 5, DECAY_SHIFT 3 → wdata = 700.
- Peak mode, same bin, sample 750 → wdata = 750.
- Short frame, s_last at bin 9:
  - frame_done with waddr 9;
  - frame_err = 1 and stays set;
  - next sample writes bin 0.
- Long frame, no s_last:
  - counter wraps after bin 1023;
  - frame_done fires there;
  - frame_err = 1.
- Reset asserted mid-frame with 2 samples in flight:
  - no further we from the old frame;
  - a fresh 1024-cycle CLEAR follows.

Source files
------------

// File: rtl/spectrum_bin_writer_pkg.sv
// Shared geometry and FSM state type for the spectrum bin RAM.
// The display reader and the writer both take their RAM shape from here.
package spectrum_bin_writer_pkg;

    localparam int SBW_NBINS       = 1024;
    localparam int SBW_ADDR_W      = 10;
    localparam int SBW_DATA_W      = 16;
    localparam int SBW_DECAY_SHIFT = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sbw_state_t;

endpackage

// File: rtl/spectrum_bin_writer_if.sv
// Sample stream, RAM read/write port and frame status of the bin writer.
// master = the writer itself, slave = the sample source plus bin RAM.
interface spectrum_bin_writer_if
    import spectrum_bin_writer_pkg::*;
#(
    parameter int ADDR_W = SBW_ADDR_W,
    parameter int DATA_W = SBW_DATA_W
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              mode_peak;

    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              we;

    logic              frame_done;
    logic              frame_err;

    modport master (
        input  s_valid, s_data, s_last, mode_peak, rdata,
        output s_ready, raddr, waddr, wdata, we, frame_done, frame_err
    );

    modport slave (
        output s_valid, s_data, s_last, mode_peak, rdata,
        input  s_ready, raddr, waddr, wdata, we, frame_done, frame_err
    );

endinterface

// File: rtl/spectrum_bin_writer_bin_update.sv
// Combinational bin update: overwrite, or peak-hold against an exponentially decayed old value.
// Zero latency; no handshake, the caller decides when the result is written.
module spectrum_bin_writer_bin_update #(
    parameter int DATA_W      = 16,
    parameter int DECAY_SHIFT = 3
) (
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] new_i,
    input  logic              mode_peak_i,
    output logic [DATA_W-1:0] wdata_o
);

    logic [DATA_W-1:0] dec;

    always_comb begin
        // old >> k never exceeds old, so the subtraction cannot underflow
        dec     = old_i - (old_i >> DECAY_SHIFT);
        wdata_o = new_i;
        if (mode_peak_i && (dec > new_i)) begin
            wdata_o = dec;
        end
    end

endmodule

// File: rtl/spectrum_bin_writer.sv
// Writes per-frame FFT magnitudes into the bin RAM by read-modify-write; clears the RAM after reset.
// Sample to RAM write is 2 cycles; 1 sample/cycle, s_ready low only while clearing.
module spectrum_bin_writer
    import spectrum_bin_writer_pkg::*;
#(
    parameter int NBINS       = SBW_NBINS,
    parameter int ADDR_W      = SBW_ADDR_W,
    parameter int DATA_W      = SBW_DATA_W,
    parameter int DECAY_SHIFT = SBW_DECAY_SHIFT
) (
    input logic                  clk,
    input logic                  reset,
    spectrum_bin_writer_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NBINS - 1);

    sbw_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic              s_ready_q, s_ready_d;

    // stage 1: sample captured while its old bin value is being read
    logic              p1_vld_q, p1_vld_d;
    logic [DATA_W-1:0] p1_dat_q, p1_dat_d;
    logic              p1_mode_q, p1_mode_d;
    logic [ADDR_W-1:0] p1_bin_q, p1_bin_d;
    logic              p1_end_q, p1_end_d;
    logic              p1_err_q, p1_err_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;

    logic              accept;
    logic              bin_at_end;
    logic              frame_end;
    logic              frame_bad;
    logic [DATA_W-1:0] upd_dat;

    spectrum_bin_writer_bin_update #(
        .DATA_W      (DATA_W),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_bin_update (
        .old_i       (bus.rdata),
        .new_i       (p1_dat_q),
        .mode_peak_i (p1_mode_q),
        .wdata_o     (upd_dat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            bin_q        <= '0;
            s_ready_q    <= 1'b0;
            p1_vld_q     <= 1'b0;
            p1_dat_q     <= '0;
            p1_mode_q    <= 1'b0;
            p1_bin_q     <= '0;
            p1_end_q     <= 1'b0;
            p1_err_q     <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            bin_q        <= bin_d;
            s_ready_q    <= s_ready_d;
            p1_vld_q     <= p1_vld_d;
            p1_dat_q     <= p1_dat_d;
            p1_mode_q    <= p1_mode_d;
            p1_bin_q     <= p1_bin_d;
            p1_end_q     <= p1_end_d;
            p1_err_q     <= p1_err_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        bin_d     = bin_q;
        // ready trails the state by a cycle so it rises after the last clear write is visible
        s_ready_d = (state_q == RUN);

        accept     = bus.s_valid && s_ready_q;
        bin_at_end = (bin_q == LAST_BIN);
        frame_end  = bus.s_last || bin_at_end;
        // s_last before the last bin is a short frame; reaching it without s_last is a long one
        frame_bad  = bus.s_last ^ bin_at_end;

        p1_vld_d  = accept;
        p1_dat_d  = bus.s_data;
        p1_mode_d = bus.mode_peak;
        p1_bin_d  = bin_q;
        p1_end_d  = accept && frame_end;
        p1_err_d  = accept && frame_bad;

        we_d         = p1_vld_q;
        waddr_d      = p1_bin_q;
        wdata_d      = upd_dat;
        frame_done_d = p1_vld_q && p1_end_q;
        frame_err_d  = frame_err_q || (p1_vld_q && p1_err_q);

        case (state_q)
            CLEAR: begin
                we_d      = 1'b1;
                waddr_d   = clr_cnt_q;
                wdata_d   = '0;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_BIN) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    bin_d = frame_end ? '0 : bin_q + ADDR_W'(1);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.raddr      = bin_q;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;

endmodule
